// File: rtl/round_robin_arbiter_with_4_requests_and_hold.sv
// -----------------------------------------------------------------------------
// round_robin_arbiter_with_4_requests_and_hold
//
// Four-requester round-robin arbiter with grant tenure. A requester that wins
// keeps its grant until it signals its final beat (request and last both
// high) or drops its request. On release the pointer moves past the owner, so
// the owner becomes the lowest priority. If other requests are pending, the
// grant passes straight to the next winner with no idle cycle.
//
// Optional watchdog: define ROUND_ROBIN_ARBITER_HOLD_TIMEOUT_EN to force a
// release after MAX_HOLD granted cycles. The forced release pulses timeout for
// one cycle. Without the macro, timeout is tied low and tenure is unbounded.
//
// Handshake: requests[i] is a level request. It stays high for the whole
// transaction. grants[i] is registered and appears one edge after arbitration.
// The owner's final granted cycle is the cycle in which requests[i] and
// last[i] are both high. last[] is ignored for every requester except the
// current owner.
//
// Parameters
//   MAX_HOLD     maximum grant tenure in cycles, legal range 2..255
// Ports
//   clk          clock; all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   requests[3:0] per-requester level request
//   last[3:0]    per-requester final-beat flag (owner only)
//   grants[3:0]  registered one-hot (or zero) grant
//   busy         OR of grants
//   timeout      one-cycle pulse on a watchdog-forced release
//   dbg_state_o  FSM state (0 = IDLE, 1 = OWNED)
//   dbg_ptr_o    round-robin priority pointer
//   dbg_hold_o   cycles the current owner has been granted, minus one
// -----------------------------------------------------------------------------
module round_robin_arbiter_with_4_requests_and_hold #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] requests,
    input  logic [3:0] last,
    output logic [3:0] grants,
    output logic       busy,
    output logic       timeout,
    output logic       dbg_state_o,
    output logic [1:0] dbg_ptr_o,
    output logic [7:0] dbg_hold_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_e;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] owner_q, owner_d;
    logic [3:0] grants_q, grants_d;
    logic [7:0] hold_q, hold_d;

    logic       owner_req;
    logic       owner_last;
    logic       hold_at_limit;
    logic       rel_force;
    logic       release_w;
    logic [3:0] cand;
    logic [1:0] base;
    logic [1:0] winner;

    // First set bit of cand, searching upward from base and wrapping mod 4.
    function automatic logic [1:0] pick(input logic [3:0] c, input logic [1:0] b);
        logic [1:0] idx;
        logic       found;
        pick  = b;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = b + 2'(i);
            if (!found && c[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    always_comb begin
        owner_req     = requests[owner_q];
        owner_last    = last[owner_q];
        hold_at_limit = (hold_q == HOLD_LIMIT);
`ifdef ROUND_ROBIN_ARBITER_HOLD_TIMEOUT_EN
        // A forced release is only a timeout if the owner was not leaving anyway.
        rel_force     = owner_req && !owner_last && hold_at_limit;
`else
        rel_force     = 1'b0;
`endif
        release_w     = (state_q == ST_OWNED) &&
                        (!owner_req || owner_last || rel_force);

        // On release, the owner is excluded from this arbitration. A request it
        // still holds can only win again through a later IDLE arbitration.
        cand = requests;
        base = ptr_q;
        if (release_w) begin
            cand = requests & ~(4'b0001 << owner_q);
            base = owner_q + 2'd1;
        end
        winner = pick(cand, base);
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        grants_d = grants_q;
        hold_d   = hold_q;

        case (state_q)
            ST_IDLE: begin
                if (|cand) begin
                    state_d  = ST_OWNED;
                    owner_d  = winner;
                    grants_d = 4'b0001 << winner;
                    hold_d   = 8'd0;
                end
            end
            ST_OWNED: begin
                if (release_w) begin
                    ptr_d  = base;
                    hold_d = 8'd0;
                    if (|cand) begin
                        owner_d  = winner;
                        grants_d = 4'b0001 << winner;
                    end else begin
                        state_d  = ST_IDLE;
                        grants_d = 4'b0000;
                    end
                end else begin
                    // Saturates at the threshold. This only matters when the
                    // watchdog is compiled out and tenure is unbounded.
                    hold_d = hold_at_limit ? hold_q : hold_q + 8'd1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                grants_d = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 2'd0;
            owner_q  <= 2'd0;
            grants_q <= 4'b0000;
            hold_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            grants_q <= grants_d;
            hold_q   <= hold_d;
        end
    end

`ifdef ROUND_ROBIN_ARBITER_HOLD_TIMEOUT_EN
    logic timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= release_w && rel_force;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign grants      = grants_q;
    assign busy        = |grants_q;
    assign dbg_state_o = state_q;
    assign dbg_ptr_o   = ptr_q;
    assign dbg_hold_o  = hold_q;

endmodule

// File: tb/tb_round_robin_arbiter_with_4_requests_and_hold.sv
module tb_round_robin_arbiter_with_4_requests_and_hold;

    logic       clk;
    logic       rst_n;
    logic [3:0] requests;
    logic [3:0] last;
    logic [3:0] grants;
    logic       busy;
    logic       timeout;
    logic       dbg_state;
    logic [1:0] dbg_ptr;
    logic [7:0] dbg_hold;

    int n_checks = 0;
    int n_fail   = 0;

    round_robin_arbiter_with_4_requests_and_hold #(.MAX_HOLD(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .requests    (requests),
        .last        (last),
        .grants      (grants),
        .busy        (busy),
        .timeout     (timeout),
        .dbg_state_o (dbg_state),
        .dbg_ptr_o   (dbg_ptr),
        .dbg_hold_o  (dbg_hold)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] exp_g,
                           input logic exp_to);
        chk({tag, " grants"},  {4'd0, grants}, {4'd0, exp_g});
        chk({tag, " busy"},    {7'd0, busy},   {7'd0, |exp_g});
        chk({tag, " timeout"}, {7'd0, timeout}, {7'd0, exp_to});
        chk({tag, " state"},   {7'd0, dbg_state}, {7'd0, |exp_g});
    endtask

    // ---------------- driver ----------------
    // Drive inputs, take one rising edge, then sample 1 time unit later.
    task automatic step(input logic [3:0] req, input logic [3:0] lst);
        requests = req;
        last     = lst;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] lst;
        logic [3:0] exp_g;
        logic [1:0] exp_ptr;
    } vec_t;

    vec_t vecs[25];

    initial begin
        // Rotation with every owner finishing in its first granted cycle.
        vecs[0]  = '{4'b1111, 4'b0000, 4'b0001, 2'd0};
        vecs[1]  = '{4'b1111, 4'b0001, 4'b0010, 2'd1};
        vecs[2]  = '{4'b1111, 4'b0010, 4'b0100, 2'd2};
        vecs[3]  = '{4'b1111, 4'b0100, 4'b1000, 2'd3};
        vecs[4]  = '{4'b1111, 4'b1000, 4'b0001, 2'd0};
        // Single requester finishing with last: back to idle, pointer moves past it.
        vecs[5]  = '{4'b0001, 4'b0001, 4'b0000, 2'd1};
        vecs[6]  = '{4'b0000, 4'b0000, 4'b0000, 2'd1};
        // Move the pointer to 2.
        vecs[7]  = '{4'b0010, 4'b0000, 4'b0010, 2'd1};
        vecs[8]  = '{4'b0010, 4'b0010, 4'b0000, 2'd2};
        // Owner 2 holds for 3 cycles, then hands over with wraparound to 0.
        vecs[9]  = '{4'b0111, 4'b0000, 4'b0100, 2'd2};
        vecs[10] = '{4'b0111, 4'b0000, 4'b0100, 2'd2};
        vecs[11] = '{4'b0111, 4'b0000, 4'b0100, 2'd2};
        vecs[12] = '{4'b0111, 4'b0100, 4'b0001, 2'd3};
        // Owner 1 abandons and nobody else is waiting.
        vecs[13] = '{4'b0011, 4'b0001, 4'b0010, 2'd1};
        vecs[14] = '{4'b0000, 4'b0000, 4'b0000, 2'd2};
        // last[] of non-owners is ignored.
        vecs[15] = '{4'b0001, 4'b1110, 4'b0001, 2'd2};
        vecs[16] = '{4'b0001, 4'b1110, 4'b0001, 2'd2};
        vecs[17] = '{4'b1001, 4'b0000, 4'b0001, 2'd2};
        vecs[18] = '{4'b1001, 4'b0001, 4'b1000, 2'd1};
        // Abandonment handing over directly to a waiting requester.
        vecs[19] = '{4'b0110, 4'b0000, 4'b0010, 2'd0};
        vecs[20] = '{4'b0000, 4'b0000, 4'b0000, 2'd2};
        // A released owner that still requests is granted again only after an idle cycle.
        vecs[21] = '{4'b0100, 4'b0000, 4'b0100, 2'd2};
        vecs[22] = '{4'b0100, 4'b0100, 4'b0000, 2'd3};
        vecs[23] = '{4'b0100, 4'b0000, 4'b0100, 2'd3};
        vecs[24] = '{4'b0000, 4'b0000, 4'b0000, 2'd3};
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n    = 1'b0;
        requests = 4'b0000;
        last     = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk_out("reset", 4'b0000, 1'b0);
        chk("reset ptr",  {6'd0, dbg_ptr}, 8'd0);
        chk("reset hold", dbg_hold, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            step(vecs[i].req, vecs[i].lst);
            chk_out($sformatf("vec%0d", i), vecs[i].exp_g, 1'b0);
            chk($sformatf("vec%0d ptr", i), {6'd0, dbg_ptr}, {6'd0, vecs[i].exp_ptr});
        end

        // Long tenure: owner 0 never signals last while requester 1 waits (pointer is 3).
        for (int i = 0; i < 4; i++) begin
            step(4'b0011, 4'b0000);
            chk_out($sformatf("hold%0d", i), 4'b0001, 1'b0);
        end
`ifdef ROUND_ROBIN_ARBITER_HOLD_TIMEOUT_EN
        step(4'b0011, 4'b0000);
        chk_out("watchdog release", 4'b0010, 1'b1);
        chk("watchdog ptr", {6'd0, dbg_ptr}, 8'd1);
        step(4'b0011, 4'b0000);
        chk_out("after watchdog", 4'b0010, 1'b0);
`else
        for (int i = 4; i < 8; i++) begin
            step(4'b0011, 4'b0000);
            chk_out($sformatf("hold%0d", i), 4'b0001, 1'b0);
        end
`endif
        step(4'b0000, 4'b0000);
        chk_out("hold cleanup", 4'b0000, 1'b0);

        // Asynchronous reset while requester 3 owns the grant.
        step(4'b1000, 4'b0000);
        chk_out("pre-reset owner3", 4'b1000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async reset", 4'b0000, 1'b0);
        chk("async reset ptr", {6'd0, dbg_ptr}, 8'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        requests = 4'b1001;
        @(posedge clk);
        #1;
        chk_out("first grant after reset", 4'b0001, 1'b0);
        chk("first grant ptr", {6'd0, dbg_ptr}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/round_robin_arbiter_with_4_requests_and_hold.md
ROUND_ROBIN_ARBITER_WITH_4_REQUESTS_AND_HOLD -- requirements
Module: round_robin_arbiter_with_4_requests_and_hold

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16: maximum grant tenure in cycles before forced release (legal range 2..255).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port requests  input  4  per-requester request, level, held high for the whole transaction.
REQ-005 SHALL have port last  input  4  per-requester final-beat flag, sampled only for the current owner.
REQ-006 SHALL have port grants  output  4  registered one-hot (or zero) grant.
REQ-007 SHALL have port busy  output  1  high when any grant bit is high (equals OR of grants).
REQ-008 SHALL have port timeout  output  1  one-cycle pulse on a forced release.

Function
REQ-009 SHALL implement two states: IDLE (grants = 0) and OWNED (exactly one grant bit high).
REQ-010 SHALL keep a 2-bit priority pointer ptr; the highest-priority requester is ptr, then ptr+1, ptr+2, ptr+3 (mod 4).
REQ-011 In IDLE with requests != 0, SHALL select the first asserted requester from ptr upward and assert its grant on the next rising edge (1-cycle latency, registered).
REQ-012 In IDLE with requests == 0, SHALL stay in IDLE with ptr unchanged.
REQ-013 In OWNED, SHALL hold the grant unchanged while the owner's request is high and the owner's last is low.
REQ-014 SHALL release the owner at the rising edge after a cycle where owner request and owner last are both high; that cycle is the owner's final granted cycle.
REQ-015 SHALL release the owner at the rising edge after a cycle where the owner's request is low (abandonment).
REQ-016 On any release, SHALL set ptr to owner+1 mod 4, so the released requester has lowest priority.
REQ-017 On release with other requests pending, SHALL arbitrate with the updated ptr in the same cycle and grant the winner on the same edge (grant moves owner-to-owner with no idle bubble).
REQ-018 On release with no other requests pending, SHALL return to IDLE (grants = 0); a still-asserted request of the released owner SHALL be re-granted only via a fresh IDLE arbitration.
REQ-019 SHALL never assert a grant bit whose request was low in the arbitrating cycle.
REQ-020 SHALL ignore last bits of non-owners and last of the owner while in IDLE.
REQ-021 SHALL keep an 8-bit hold counter, cleared on every new grant, incremented each OWNED cycle.

Reset
REQ-022 While rst_n is low, SHALL force grants = 0, busy = 0, timeout = 0, state = IDLE, ptr = 0, hold counter = 0, asynchronously.
REQ-023 Reset asserted mid-transaction SHALL drop the grant immediately without waiting for a clock; first grant after rst_n rises follows REQ-011 with ptr = 0.

Configuration
REQ-024 Macro ROUND_ROBIN_ARBITER_HOLD_TIMEOUT_EN SHALL select the watchdog feature.
REQ-025 With the macro defined, when the hold counter reaches MAX_HOLD-1 without release, SHALL force a release per REQ-016/REQ-017 on the next edge and pulse timeout high for exactly that one cycle.
REQ-026 Without the macro, SHALL have no watchdog: timeout port present and tied 0, tenure unbounded, hold counter optional.

Verification
REQ-027 Reset, then requests=0001, last=0001 one cycle -> grants=0001 for exactly one cycle next edge, then 0000, ptr=1.
REQ-028 From ptr=0, requests=1111 held, each owner asserts last in its first granted cycle -> grants sequence 0001,0010,0100,1000,0001 with no 0000 cycles.
REQ-029 Owner 2 holding 3 cycles while requests=0111 -> grants stays 0100 for 3 cycles, on owner 2's last grants becomes 0001 (ptr=3 wraps to 0).
REQ-030 Owner 1 drops request without last, requests=0000 -> grants=0000 next edge, busy=0, ptr=2.
REQ-031 Macro defined, MAX_HOLD=4, owner 0 never asserts last, requests=0011 -> grants=0001 for 4 cycles, then timeout=1 one cycle with grants=0010.
REQ-032 rst_n pulsed low while grants=1000 -> grants=0000 before next edge; after release requests=1001 -> grants=0001.
